// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-line instruction cache with flush-safe miss handling
module icache #(
  parameter int LINES = 256,
  parameter int IDX_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        req_flg,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        ret_flg,
  output logic [31:0] ret_ins,
  output logic        mem_req_flg,
  output logic [31:0] mem_addr,
  input  logic        mem_flg,
  input  logic [31:0] mem_ins
);

  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MISS,
    S_DRAIN
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [31:0]        r_data [LINES];
  logic [IDX_W-1:0]   r_fill_idx;
  logic [TAG_W-1:0]   r_fill_tag;
  logic               r_ret_flg;
  logic [31:0]        r_ret_ins;
  logic               r_mem_req_flg;
  logic [31:0]        r_mem_addr;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic               w_accept;
  logic               w_ret_flg_nx;
  logic [31:0]        w_ret_ins_nx;
  logic               w_mem_req_nx;
  logic [31:0]        w_mem_addr_nx;
  logic               w_latch;
  logic               w_fill;
  logic               w_unused;

  // Byte offset within the word never affects a fetch.
  assign w_unused = ^req_addr[1:0];

  assign w_idx    = req_addr[IDX_W+1:2];
  assign w_tag    = req_addr[31:IDX_W+2];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // A request still held while its return pulse is visible must not be taken twice.
  assign w_accept = req_flg && !flush && !r_ret_flg;

  assign ret_flg     = r_ret_flg;
  assign ret_ins     = r_ret_ins;
  assign mem_req_flg = r_mem_req_flg;
  assign mem_addr    = r_mem_addr;

  // Next-state and next-output decode; the memory request is kept up through a flush.
  always_comb begin
    w_state_nx    = r_state;
    w_ret_flg_nx  = 1'b0;
    w_ret_ins_nx  = r_ret_ins;
    w_mem_req_nx  = r_mem_req_flg;
    w_mem_addr_nx = r_mem_addr;
    w_latch       = 1'b0;
    w_fill        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_hit) begin
            w_ret_flg_nx = 1'b1;
            w_ret_ins_nx = r_data[w_idx];
          end else begin
            w_mem_req_nx  = 1'b1;
            w_mem_addr_nx = {req_addr[31:2], 2'b00};
            w_latch       = 1'b1;
            w_state_nx    = S_MISS;
          end
        end
      end
      S_MISS: begin
        if (mem_flg) begin
          w_fill       = 1'b1;
          w_mem_req_nx = 1'b0;
          w_state_nx   = S_IDLE;
          if (!flush) begin
            w_ret_flg_nx = 1'b1;
            w_ret_ins_nx = mem_ins;
          end
        end else if (flush) begin
          w_state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_flg) begin
          w_fill       = 1'b1;
          w_mem_req_nx = 1'b0;
          w_state_nx   = S_IDLE;
        end
      end
      default: begin
        w_mem_req_nx = 1'b0;
        w_state_nx   = S_IDLE;
      end
    endcase
  end

  // State, registered outputs, valid bits and the pending-fill pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_valid       <= '0;
      r_ret_flg     <= 1'b0;
      r_ret_ins     <= '0;
      r_mem_req_flg <= 1'b0;
      r_mem_addr    <= '0;
      r_fill_idx    <= '0;
      r_fill_tag    <= '0;
    end else if (rdy) begin
      r_state       <= w_state_nx;
      r_ret_flg     <= w_ret_flg_nx;
      r_ret_ins     <= w_ret_ins_nx;
      r_mem_req_flg <= w_mem_req_nx;
      r_mem_addr    <= w_mem_addr_nx;
      if (w_latch) begin
        r_fill_idx <= w_idx;
        r_fill_tag <= w_tag;
      end
      if (w_fill) begin
        r_valid[r_fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays are written only when a fetched word lands.
  always_ff @(posedge clk) begin
    if (rst && rdy && w_fill) begin
      r_tag[r_fill_idx]  <= r_fill_tag;
      r_data[r_fill_idx] <= mem_ins;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - randomized bench for icache against a transaction-level cache model
module tb_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        req_flg = 1'b0;
  logic [31:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        ret_flg;
  logic [31:0] ret_ins;
  logic        mem_req_flg;
  logic [31:0] mem_addr;
  logic        mem_flg = 1'b0;
  logic [31:0] mem_ins = '0;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  icache #(.LINES(256), .IDX_W(8)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .req_flg(req_flg), .req_addr(req_addr),
    .flush(flush), .ret_flg(ret_flg), .ret_ins(ret_ins), .mem_req_flg(mem_req_flg),
    .mem_addr(mem_addr), .mem_flg(mem_flg), .mem_ins(mem_ins)
  );

  always #5 clk = ~clk;

  // Reference: a lookup table of cached words and one optional outstanding fetch.
  bit          m_valid [256];
  bit [21:0]   m_tagv  [256];
  bit [31:0]   m_data  [256];
  bit          m_pending;
  bit          m_deliver;
  bit [31:0]   m_paddr;
  bit          m_ret;
  bit [31:0]   m_ins;
  bit          m_mreq;
  bit [31:0]   m_maddr;

  always @(posedge clk) begin
    int  i;
    bit  nret;
    if (!rst) begin
      foreach (m_valid[k]) m_valid[k] = 1'b0;
      m_pending = 0; m_deliver = 0;
      m_ret = 0; m_ins = 0; m_mreq = 0; m_maddr = 0;
    end else if (rdy) begin
      nret = 0;
      if (!m_pending) begin
        if (req_flg && !flush && !m_ret) begin
          i = (req_addr >> 2) % 256;
          if (m_valid[i] && m_tagv[i] == 22'(req_addr >> 10)) begin
            nret  = 1;
            m_ins = m_data[i];
          end else begin
            m_pending = 1;
            m_deliver = 1;
            m_paddr   = req_addr & 32'hFFFF_FFFC;
            m_mreq    = 1;
            m_maddr   = m_paddr;
          end
        end
      end else if (mem_flg) begin
        i = (m_paddr >> 2) % 256;
        m_valid[i] = 1;
        m_tagv[i]  = 22'(m_paddr >> 10);
        m_data[i]  = mem_ins;
        m_pending  = 0;
        m_mreq     = 0;
        if (m_deliver && !flush) begin
          nret  = 1;
          m_ins = mem_ins;
        end
      end else if (flush) begin
        m_deliver = 0;
      end
      m_ret = nret;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Every cycle, all outputs against the model, sampled mid-period.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ret_flg", ret_flg, 32'(m_ret));
      chk("ret_ins", ret_ins, m_ins);
      chk("mem_req_flg", mem_req_flg, 32'(m_mreq));
      chk("mem_addr", mem_addr, m_maddr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic miss_fill(input logic [31:0] a, input logic [31:0] d, input int lat);
    req_flg = 1; req_addr = a;
    tick();
    chk("miss_req", mem_req_flg, 1);
    chk("miss_addr", mem_addr, a & 32'hFFFF_FFFC);
    chk("miss_noret", ret_flg, 0);
    repeat (lat) tick();
    chk("miss_hold", mem_req_flg, 1);
    mem_flg = 1; mem_ins = d;
    tick();
    mem_flg = 0; req_flg = 0;
    chk("fill_ret", ret_flg, 1);
    chk("fill_ins", ret_ins, d);
    chk("fill_mreq", mem_req_flg, 0);
    tick();
    chk("fill_pulse", ret_flg, 0);
  endtask

  task automatic hit(input logic [31:0] a, input logic [31:0] d);
    req_flg = 1; req_addr = a;
    tick();
    req_flg = 0;
    chk("hit_ret", ret_flg, 1);
    chk("hit_ins", ret_ins, d);
    chk("hit_mreq", mem_req_flg, 0);
    tick();
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  initial begin
    logic [31:0] a;
    rst = 0;
    tick(); tick();
    cmp_en = 1;
    chk("rst_ret", ret_flg, 0);
    chk("rst_mreq", mem_req_flg, 0);
    chk("rst_maddr", mem_addr, 0);
    rst = 1;

    miss_fill(32'h0000_0000, 32'h0000_0013, 2);
    hit(32'h0000_0000, 32'h0000_0013);
    miss_fill(32'h0000_0400, 32'h0010_0093, 1);
    miss_fill(32'h0000_0000, 32'h0000_0013, 0);

    // flush two cycles into a miss: request held until the word lands, no return
    req_flg = 1; req_addr = 32'h8;
    tick(); tick();
    flush = 1; req_flg = 0;
    tick();
    flush = 0;
    chk("drain_req", mem_req_flg, 1);
    tick();
    mem_flg = 1; mem_ins = 32'hDEAD_BEEF;
    tick();
    mem_flg = 0;
    chk("drain_noret", ret_flg, 0);
    chk("drain_mreq", mem_req_flg, 0);
    tick();
    hit(32'h8, 32'hDEAD_BEEF);

    // pause during a miss
    req_flg = 1; req_addr = 32'hC;
    tick();
    rdy = 0;
    repeat (5) begin
      tick();
      chk("pause_mreq", mem_req_flg, 1);
      chk("pause_maddr", mem_addr, 32'hC);
      chk("pause_ret", ret_flg, 0);
    end
    rdy = 1;
    mem_flg = 1; mem_ins = 32'h1234_5678;
    tick();
    mem_flg = 0; req_flg = 0;
    chk("pause_ret_done", ret_flg, 1);
    chk("pause_ins_done", ret_ins, 32'h1234_5678);
    tick();

    // flush together with the returning word: fill but no return
    req_flg = 1; req_addr = 32'h20;
    tick();
    mem_flg = 1; flush = 1; mem_ins = 32'h0000_0055; req_flg = 0;
    tick();
    mem_flg = 0; flush = 0;
    chk("flfill_noret", ret_flg, 0);
    chk("flfill_mreq", mem_req_flg, 0);
    tick();
    hit(32'h20, 32'h0000_0055);

    // flush in IDLE blocks acceptance of a hit
    req_flg = 1; req_addr = 32'h0; flush = 1;
    tick();
    flush = 0;
    chk("idle_flush", ret_flg, 0);
    tick();
    req_flg = 0;
    chk("after_flush_hit", ret_flg, 1);
    chk("after_flush_ins", ret_ins, 32'h13);
    tick();

    // reset during a miss
    req_flg = 1; req_addr = 32'h10;
    tick();
    rst = 0; req_flg = 0;
    tick();
    rst = 1;
    chk("rst_miss_mreq", mem_req_flg, 0);
    chk("rst_miss_ret", ret_flg, 0);
    miss_fill(32'h0000_0000, 32'h0000_0013, 1);

    // randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst   = ($urandom_range(0, 299) != 0);
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 24) == 0);
      if (!rst || flush || ret_flg) begin
        req_flg = 0;
      end else if (!req_flg && $urandom_range(0, 2) == 0) begin
        a = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 2)
            | 32'($urandom_range(0, 3));
        req_addr = a;
        req_flg  = 1;
      end
      mem_flg = rst && rdy && mem_req_flg && ($urandom_range(0, 2) == 0);
      mem_ins = mem_flg ? word_of(mem_addr) : $urandom;
      tick();
    end
    mem_flg = 0; req_flg = 0; flush = 0; rdy = 1; rst = 1;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
